// File: rtl/beta_lsu_ext_if.sv
`default_nettype none
// ============================================================================
// beta_lsu_ext_if
// Execute-stage request and split data-memory port bundle for beta_lsu_ext.
// Revision: 1.0
// ============================================================================
interface beta_lsu_ext_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 12
);
    logic [DATA_WIDTH-1:0]     op_data_i;
    logic [ADDR_WIDTH-1:0]     op_addr_i;
    logic [OFFSET_WIDTH-1:0]   lsu_offset_i;
    logic                      lsu_op_en_i;
    logic                      lsu_op_i;
    logic [1:0]                lsu_op_size_i;
    logic                      lsu_op_unsigned_i;

    logic                      rdata_ready_i;
    logic                      rdata_valid_i;
    logic                      rdata_err_i;
    logic [DATA_WIDTH-1:0]     rdata_data_i;
    logic [ADDR_WIDTH-1:0]     rdata_addr_o;
    logic [DATA_WIDTH/8-1:0]   rdata_strb_o;
    logic                      rdata_req_o;

    logic                      wdata_ready_i;
    logic                      wdata_valid_i;
    logic                      wdata_err_i;
    logic [DATA_WIDTH-1:0]     wdata_data_o;
    logic [ADDR_WIDTH-1:0]     wdata_addr_o;
    logic [DATA_WIDTH/8-1:0]   wdata_strb_o;
    logic                      wdata_req_o;

    logic                      lsu_busy_o;
    logic                      lsu_done_o;
    logic [DATA_WIDTH-1:0]     lsu_result_o;
    logic [1:0]                lsu_misalig_op_o;
    logic [1:0]                lsu_bus_err_o;
    logic                      lsu_timeout_o;

    modport slave (
        input  op_data_i, op_addr_i, lsu_offset_i, lsu_op_en_i, lsu_op_i,
               lsu_op_size_i, lsu_op_unsigned_i,
               rdata_ready_i, rdata_valid_i, rdata_err_i, rdata_data_i,
               wdata_ready_i, wdata_valid_i, wdata_err_i,
        output rdata_addr_o, rdata_strb_o, rdata_req_o,
               wdata_data_o, wdata_addr_o, wdata_strb_o, wdata_req_o,
               lsu_busy_o, lsu_done_o, lsu_result_o, lsu_misalig_op_o,
               lsu_bus_err_o, lsu_timeout_o
    );

    modport master (
        output op_data_i, op_addr_i, lsu_offset_i, lsu_op_en_i, lsu_op_i,
               lsu_op_size_i, lsu_op_unsigned_i,
               rdata_ready_i, rdata_valid_i, rdata_err_i, rdata_data_i,
               wdata_ready_i, wdata_valid_i, wdata_err_i,
        input  rdata_addr_o, rdata_strb_o, rdata_req_o,
               wdata_data_o, wdata_addr_o, wdata_strb_o, wdata_req_o,
               lsu_busy_o, lsu_done_o, lsu_result_o, lsu_misalig_op_o,
               lsu_bus_err_o, lsu_timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/beta_lsu_ext.sv
`default_nettype none
// ============================================================================
// beta_lsu_ext
// Single-FSM load/store unit: EA calc, lane steering, load extension, errors.
// Revision: 1.0
// ============================================================================
module beta_lsu_ext #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk_i,
    input  logic           rst_i,
    beta_lsu_ext_if.slave  bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

    state_t                r_state;
    logic                  r_op;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [LANE_W-1:0]     r_lane;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [STRB_W-1:0]     r_strb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rreq;
    logic                  r_wreq;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic [1:0]            r_misalig;
    logic [1:0]            r_bus_err;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_cnt;

    logic [ADDR_WIDTH-1:0] w_ea;
    logic [LANE_W-1:0]     w_lane;
    logic                  w_misalig;
    logic [STRB_W-1:0]     w_base_strb;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [6:0]            w_nbits;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_ready;
    logic                  w_valid;
    logic                  w_err;
    logic                  w_tmo_hit;

    assign w_ea   = bus.op_addr_i + ADDR_WIDTH'($signed(bus.lsu_offset_i));
    assign w_lane = w_ea[LANE_W-1:0];

    always_comb begin
        w_misalig   = 1'b0;
        w_base_strb = STRB_W'(8'h01);
        case (bus.lsu_op_size_i)
            2'b00: w_misalig = 1'b0;
            2'b01: begin w_misalig = w_ea[0];         w_base_strb = STRB_W'(8'h03); end
            2'b10: begin w_misalig = |w_ea[1:0];      w_base_strb = STRB_W'(8'h0F); end
            default: begin
                w_misalig   = (DATA_WIDTH == 64) ? (|w_ea[2:0]) : 1'b1;
                w_base_strb = STRB_W'(8'hFF);
            end
        endcase
    end

    // Load extension: mask keeps the selected width, its top bit gives the sign.
    assign w_shifted = bus.rdata_data_i >> {r_lane, 3'b000};
    always_comb begin
        w_nbits = 7'd8;
        case (r_size)
            2'b00:   w_nbits = 7'd8;
            2'b01:   w_nbits = 7'd16;
            2'b10:   w_nbits = 7'd32;
            default: w_nbits = 7'(DATA_WIDTH);
        endcase
    end
    assign w_mask = ~({DATA_WIDTH{1'b1}} << w_nbits);
    assign w_sign = ~r_unsigned & (|(w_shifted & w_mask & ~(w_mask >> 1)));
    assign w_ext  = (w_shifted & w_mask) | ({DATA_WIDTH{w_sign}} & ~w_mask);

    assign w_ready   = r_op ? bus.wdata_ready_i : bus.rdata_ready_i;
    assign w_valid   = r_op ? bus.wdata_valid_i : bus.rdata_valid_i;
    assign w_err     = r_op ? bus.wdata_err_i   : bus.rdata_err_i;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt >= c_cnt_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= '0;
            r_addr     <= '0;
            r_strb     <= '0;
            r_wdata    <= '0;
            r_rreq     <= 1'b0;
            r_wreq     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_misalig  <= 2'b00;
            r_bus_err  <= 2'b00;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_misalig <= 2'b00;
            r_bus_err <= 2'b00;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.lsu_op_en_i) begin
                        if (w_misalig) begin
                            r_done    <= 1'b1;
                            r_misalig <= bus.lsu_op_i ? 2'b10 : 2'b01;
                        end else begin
                            r_op       <= bus.lsu_op_i;
                            r_size     <= bus.lsu_op_size_i;
                            r_unsigned <= bus.lsu_op_unsigned_i;
                            r_lane     <= w_lane;
                            r_addr     <= w_ea & ~ADDR_WIDTH'(STRB_W - 1);
                            r_strb     <= w_base_strb << w_lane;
                            r_wdata    <= bus.op_data_i << {w_lane, 3'b000};
                            r_rreq     <= ~bus.lsu_op_i;
                            r_wreq     <= bus.lsu_op_i;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ, S_RESP: begin
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
                    // A handshake in the limit cycle takes priority over the abort.
                    if (r_state == S_REQ && w_ready) begin
                        r_rreq  <= 1'b0;
                        r_wreq  <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_state == S_RESP && w_valid) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        if (w_err)      r_bus_err <= r_op ? 2'b10 : 2'b01;
                        else if (!r_op) r_result  <= w_ext;
                    end else if (w_tmo_hit) begin
                        r_rreq    <= 1'b0;
                        r_wreq    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata_addr_o     = r_addr;
    assign bus.rdata_strb_o     = r_strb;
    assign bus.rdata_req_o      = r_rreq;
    assign bus.wdata_addr_o     = r_addr;
    assign bus.wdata_strb_o     = r_strb;
    assign bus.wdata_data_o     = r_wdata;
    assign bus.wdata_req_o      = r_wreq;
    assign bus.lsu_busy_o       = r_busy;
    assign bus.lsu_done_o       = r_done;
    assign bus.lsu_result_o     = r_result;
    assign bus.lsu_misalig_op_o = r_misalig;
    assign bus.lsu_bus_err_o    = r_bus_err;
    assign bus.lsu_timeout_o    = r_timeout;
endmodule
`default_nettype wire

// File: doc/beta_lsu_ext.md
Name: beta_lsu_ext

Overview:
Parametrised successor load/store unit for the beta core execute stage. A single FSM serves both loads and stores on split read/write data-memory ports. It adds several capabilities: effective-address computation for both ops, sub-word byte-lane steering, load sign/zero extension, memory error reporting, a transaction timeout and a completion pulse. It sits between the execute control unit and the data memory interface.

Parameters:
DataWidth, 32, bus data width in bits; legal values are 32 and 64.
AddressWidth, 32, byte address width.
OffsetWidth, 12, signed immediate offset width; sign-extended to AddressWidth.
TimeoutCycles, 256, maximum cycles spent in REQ+RESP before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
op_data_i  in  DataWidth  store data, right-aligned
op_addr_i  in  AddressWidth  base address
lsu_offset_i  in  OffsetWidth  signed offset, used for loads and stores
lsu_op_en_i  in  1  start request, sampled in IDLE only
lsu_op_i  in  1  0 = load, 1 = store
lsu_op_size_i  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DataWidth=64; otherwise treated as misaligned)
lsu_op_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend load
rdata_ready_i / rdata_valid_i / rdata_err_i  in  1 each  read port handshake; err is qualified by valid
rdata_data_i  in  DataWidth  read data
rdata_addr_o  out  AddressWidth  aligned read address
rdata_strb_o  out  DataWidth/8  read byte strobe
rdata_req_o  out  1  read request
wdata_ready_i / wdata_valid_i / wdata_err_i  in  1 each  write port handshake
wdata_data_o  out  DataWidth  lane-shifted write data
wdata_addr_o  out  AddressWidth  aligned write address
wdata_strb_o  out  DataWidth/8  write byte strobe
wdata_req_o  out  1  write request
lsu_busy_o  out  1  transaction in flight
lsu_done_o  out  1  one-cycle completion pulse, all outcomes
lsu_result_o  out  DataWidth  extended load result
lsu_misalig_op_o  out  2  [0] load misaligned, [1] store misaligned; one-cycle pulse
lsu_bus_err_o  out  2  [0] load error, [1] store error; one-cycle pulse
lsu_timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-transaction aborts immediately, and no done pulse is issued.
- Effective address: ea = op_addr_i + sext(lsu_offset_i), modulo 2^AddressWidth.
- Lane: lane = ea[log2(DataWidth/8)-1:0]. Bus address = ea with lane bits cleared.
- Misalignment: half requires ea[0]=0; word requires ea[1:0]=0; dword requires ea[2:0]=0.
- Strobe: base mask (1, 3, F, FF) shifted left by lane.
- wdata_data_o = op_data_i << (8*lane).
- FSM IDLE:
  - en=1 and misaligned: no request is issued and busy stays 0. Next cycle: the matching lsu_misalig_op_o bit and lsu_done_o pulse for one cycle.
  - en=1 and aligned: register address, strobe and data; assert req on the selected port and busy; go to REQ.
  - en while busy is ignored.
- REQ: hold req, address, strobe and data stable until ready=1. Then drop req next cycle and go to RESP. Valid seen in REQ is ignored.
- RESP: on valid=1, go to IDLE. Next cycle busy=0 and done pulses.
  - Load with err=0: lsu_result_o = extend((rdata_data_i >> 8*lane) truncated to size).
  - Store: lsu_result_o is unchanged.
  - err=1: lsu_bus_err_o[op] pulses and lsu_result_o is unchanged.
- Timeout (TimeoutCycles>0):
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TimeoutCycles: req=0, go to IDLE, busy=0, and lsu_timeout_o and done pulse. Responses arriving afterwards are ignored.
  - ready or valid arriving in the same cycle the counter reaches TimeoutCycles wins over the timeout.
- Latency:
  - en at cycle 0 → req at 1.
  - ready at cycle k → RESP from k+1.
  - valid at cycle m → result and done at m+1.
  - Minimum: done at cycle 3.
- lsu_result_o holds its value until the next successful load completes.

Test Plan:
- Aligned word load: base 0x1000, offset 4, valid data 0xDEADBEEF → rdata_addr_o=0x1004, strb=F; at done, result=0xDEADBEEF, busy 0.
- Signed byte load: ea=0x2003, data 0x80xxxxxx, unsigned=0 → strb=8, result=0xFFFFFF80. With unsigned=1 → result=0x00000080.
- Half store: base 0x3000, offset -2 (0xFFE), op_data 0x1234 → wdata_addr_o=0x2FFC, strb=C, wdata_data_o=0x12340000, result unchanged.
- Misaligned word store: ea=0x101 → no wdata_req_o; lsu_misalig_op_o=2'b10 and done for 1 cycle; busy never high.
- Error and timeout: load with rdata_err_i=1 at valid → lsu_bus_err_o=2'b01 and result unchanged. Separately, TimeoutCycles=8 with ready never asserted → req drops, lsu_timeout_o pulses 8 cycles after REQ entry.
- Async reset: assert rst_i in RESP → outputs 0 without a clock edge; a new load after release completes normally.
